// File: rtl/btn_evt.sv
// btn_evt: turns a debounced button level into single-cycle event pulses.
// It reports press, release, click, double-click and long-press.
// One shared duration counter is used. It times the hold in the first press,
// and it times the double-click window after a short release.
module btn_evt #(
  parameter int unsigned CNT_W        = 26,
  parameter int unsigned LONG_CLKS    = 50_000_000,
  parameter int unsigned DBL_WIN_CLKS = 25_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic i_sig,
  output logic o_press,
  output logic o_release,
  output logic o_click,
  output logic o_dbl,
  output logic o_long
);

  // IDLE  : no sequence in progress
  // HELD  : first press is held; cnt counts the hold duration
  // WAIT  : short first press released; cnt counts the double-click window
  // HELD2 : second press is held; its duration does not matter
  // LONG  : long-press already reported; wait for the release quietly
  typedef enum logic [2:0] {
    IDLE,
    HELD,
    WAIT,
    HELD2,
    LONG
  } state_t;

  // Compare limits and the increment are sized to the counter.
  // All compares are then unsigned CNT_W-bit compares.
  localparam logic [CNT_W-1:0] LONG_LIM = CNT_W'(LONG_CLKS);
  localparam logic [CNT_W-1:0] DBL_LIM  = CNT_W'(DBL_WIN_CLKS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             prev;
  logic             rise;
  logic             fall;
  logic             long_nxt;
  logic             click_nxt;
  logic             dbl_nxt;

  // Edges are found against the level seen on the previous clock.
  // Reset clears prev. So a button that is held through reset is reported
  // as a fresh press on the first clock after reset is released.
  assign rise = i_sig & ~prev;
  assign fall = ~i_sig & prev;

  // Sequence decoding. This block picks the next state and counter value.
  // It also decides which event pulse, if any, is launched on this edge.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    long_nxt  = 1'b0;
    click_nxt = 1'b0;
    dbl_nxt   = 1'b0;

    case (state)
      IDLE: begin
        if (rise) begin
          state_nxt = HELD;
          cnt_nxt   = CNT_ONE;
        end
      end

      HELD: begin
        if (i_sig) begin
          if (cnt == LONG_LIM) begin
            long_nxt  = 1'b1;
            state_nxt = LONG;
          end else begin
            cnt_nxt = cnt + CNT_ONE;
          end
        end else if (fall) begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_ONE;
        end
      end

      WAIT: begin
        // A press on the last clock of the window still counts as a
        // second press. So rise is checked before the timeout.
        if (rise) begin
          state_nxt = HELD2;
        end else if (cnt == DBL_LIM) begin
          click_nxt = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end

      HELD2: begin
        if (fall) begin
          dbl_nxt   = 1'b1;
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      LONG: begin
        if (fall) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end
      end

      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // State, duration counter and previous-level register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      prev  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      prev  <= i_sig;
    end
  end

  // Registered event pulses. Each one is high for exactly one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_press   <= 1'b0;
      o_release <= 1'b0;
      o_click   <= 1'b0;
      o_dbl     <= 1'b0;
      o_long    <= 1'b0;
    end else begin
      o_press   <= rise;
      o_release <= fall;
      o_click   <= click_nxt;
      o_dbl     <= dbl_nxt;
      o_long    <= long_nxt;
    end
  end

endmodule

// File: tb/tb_btn_evt.sv
// Self-checking bench for btn_evt with small timing parameters.
// A timestamp-based event model is checked on every clock.
// Per-scenario pulse logs are compared against hand-computed edge lists.
module tb_btn_evt;

  localparam int L     = 8;
  localparam int D     = 5;
  localparam int W     = 4;
  localparam int NEDGE = 40;

  logic clk = 1'b0;
  logic rst;
  logic i_sig;
  logic o_press;
  logic o_release;
  logic o_click;
  logic o_dbl;
  logic o_long;

  int checks   = 0;
  int failures = 0;
  int cur_edge = -1;

  logic [63:0] m_press;
  logic [63:0] m_rel;
  logic [63:0] m_click;
  logic [63:0] m_dbl;
  logic [63:0] m_long;

  btn_evt #(
    .CNT_W(W),
    .LONG_CLKS(L),
    .DBL_WIN_CLKS(D)
  ) dut (
    .clk(clk),
    .rst(rst),
    .i_sig(i_sig),
    .o_press(o_press),
    .o_release(o_release),
    .o_click(o_click),
    .o_dbl(o_dbl),
    .o_long(o_long)
  );

  // 10-time-unit clock. Stimulus changes on the falling edge.
  always #5 clk = ~clk;

  // Mask with bits lo..hi set.
  function automatic logic [63:0] rng(input int lo, input int hi);
    logic [63:0] m;
    m = '0;
    for (int i = lo; i <= hi; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Mask with a single bit set.
  function automatic logic [63:0] bitAt(input int i);
    logic [63:0] m;
    m = '0;
    m[i] = 1'b1;
    return m;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("[TB] FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Reset the DUT, then drive one scenario.
  // sig_pat[k] and rst_pat[k] are the values sampled at scenario edge k.
  task automatic applyStimulus(input logic [63:0] sig_pat, input logic [63:0] rst_pat);
    @(negedge clk);
    rst      = 1'b1;
    i_sig    = 1'b0;
    cur_edge = -1;
    @(negedge clk);
    @(negedge clk);
    m_press = '0;
    m_rel   = '0;
    m_click = '0;
    m_dbl   = '0;
    m_long  = '0;
    for (int k = 0; k < NEDGE; k++) begin
      if (k > 0) @(negedge clk);
      rst      = rst_pat[k];
      i_sig    = sig_pat[k];
      cur_edge = k;
    end
    @(negedge clk);
    cur_edge = -1;
    i_sig    = 1'b0;
  endtask

  task automatic runScenario(input string name, input logic [63:0] sig_pat,
                             input logic [63:0] rst_pat, input logic [63:0] e_press,
                             input logic [63:0] e_rel, input logic [63:0] e_click,
                             input logic [63:0] e_dbl, input logic [63:0] e_long);
    applyStimulus(sig_pat, rst_pat);
    checkOutput({name, ".press"}, m_press, e_press);
    checkOutput({name, ".release"}, m_rel, e_rel);
    checkOutput({name, ".click"}, m_click, e_click);
    checkOutput({name, ".dbl"}, m_dbl, e_dbl);
    checkOutput({name, ".long"}, m_long, e_long);
  endtask

  // Event model in terms of edge timestamps. On each clock it predicts
  // {press, release, click, dbl, long} and compares them with the DUT.
  // It also logs the DUT pulses by scenario edge.
  initial begin : scoreboard
    int   n;
    int   t_rise;
    int   t_rel;
    int   s_edge;
    bit   s_sig;
    bit   s_rst;
    bit   m_prev;
    bit   pending;
    bit   second;
    bit   long_done;
    bit   in_press;
    bit   rise;
    bit   fall;
    logic [4:0] exp_v;
    logic [4:0] got_v;
    n = 0; t_rise = 0; t_rel = 0; m_prev = 0;
    pending = 0; second = 0; long_done = 0; in_press = 0;
    forever begin
      @(posedge clk);
      s_sig  = i_sig;
      s_rst  = rst;
      s_edge = cur_edge;
      #1;
      exp_v = '0;
      if (s_rst) begin
        m_prev = 0; pending = 0; second = 0; long_done = 0; in_press = 0;
      end else begin
        rise = s_sig && !m_prev;
        fall = !s_sig && m_prev;
        exp_v[4] = rise;
        exp_v[3] = fall;
        if (in_press && !second && !long_done && s_sig && (n - t_rise == L)) begin
          exp_v[0]  = 1'b1;
          long_done = 1;
        end
        if (pending && !rise && (n - t_rel == D)) begin
          exp_v[2] = 1'b1;
          pending  = 0;
        end
        if (rise) begin
          second    = pending && (n - t_rel <= D);
          pending   = 0;
          in_press  = 1;
          t_rise    = n;
          long_done = 0;
        end
        if (fall) begin
          if (second) exp_v[1] = 1'b1;
          else if (!long_done) begin
            pending = 1;
            t_rel   = n;
          end
          in_press = 0;
          second   = 0;
        end
        m_prev = s_sig;
      end
      got_v = {o_press, o_release, o_click, o_dbl, o_long};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("[TB] FAIL cycle %0d (edge %0d) {press,rel,click,dbl,long}: got %b want %b",
                 n, s_edge, got_v, exp_v);
      end
      if (s_edge >= 0) begin
        if (o_press)   m_press[s_edge] = 1'b1;
        if (o_release) m_rel[s_edge]   = 1'b1;
        if (o_click)   m_click[s_edge] = 1'b1;
        if (o_dbl)     m_dbl[s_edge]   = 1'b1;
        if (o_long)    m_long[s_edge]  = 1'b1;
      end
      n++;
    end
  end

  initial begin : stimulus
    rst   = 1'b1;
    i_sig = 1'b0;
    #1;
    checkOutput("reset_state", {59'd0, o_press, o_release, o_click, o_dbl, o_long}, 64'd0);

    $display("[TB] single click");
    runScenario("single", rng(10, 12), 64'd0,
                bitAt(10), bitAt(13), bitAt(18), 64'd0, 64'd0);

    $display("[TB] long press");
    runScenario("long", rng(10, 25), 64'd0,
                bitAt(10), bitAt(26), 64'd0, 64'd0, bitAt(18));

    $display("[TB] long boundary");
    runScenario("long_edge", rng(10, 17), 64'd0,
                bitAt(10), bitAt(18), bitAt(23), 64'd0, 64'd0);

    $display("[TB] double click");
    runScenario("double", rng(10, 11) | rng(15, 16), 64'd0,
                bitAt(10) | bitAt(15), bitAt(12) | bitAt(17), 64'd0, bitAt(17), 64'd0);

    $display("[TB] window edge, second rise on last window clock");
    runScenario("win_in", rng(10, 11) | rng(17, 18), 64'd0,
                bitAt(10) | bitAt(17), bitAt(12) | bitAt(19), 64'd0, bitAt(19), 64'd0);

    $display("[TB] window edge, second rise one clock late");
    runScenario("win_out", rng(10, 11) | rng(18, 19), 64'd0,
                bitAt(10) | bitAt(18), bitAt(12) | bitAt(20), bitAt(17) | bitAt(25),
                64'd0, 64'd0);

    $display("[TB] reset mid-hold");
    runScenario("rst_hold", rng(10, 30), bitAt(14),
                bitAt(10) | bitAt(15), bitAt(31), 64'd0, 64'd0, bitAt(23));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/btn_evt.md
Name: btn_evt

Overview:
- Event decoder for a debounced push-button level; sits directly downstream of the signal debouncer and consumes its clean output.
- Converts the level into single-cycle event pulses: press, release, click, double-click and long-press.
- Consumers (UI FSMs, mode selectors) act on pulses and never see raw levels.

Parameters:
CNT_W, 26, width of the shared duration counter
LONG_CLKS, 50_000_000, clocks a press must be held for o_long (0.5 s at 100 MHz)
DBL_WIN_CLKS, 25_000_000, clocks after a short release during which a second press makes a double-click
- Legal range: 2 <= LONG_CLKS, DBL_WIN_CLKS <= 2^CNT_W - 1.

Ports:
clk  input  1  system clock; all logic on posedge
rst  input  1  asynchronous, active-high reset
i_sig  input  1  debounced button level, synchronous to clk, 1 = pressed
o_press  output  1  1-clk pulse on rising edge of i_sig
o_release  output  1  1-clk pulse on falling edge of i_sig
o_click  output  1  1-clk pulse: single short press, no second press within window
o_dbl  output  1  1-clk pulse: second press released within the double-click sequence
o_long  output  1  1-clk pulse: press held LONG_CLKS clocks

Behaviour:
- Clocking and reset:
  - One clock, clk. Reset rst is asynchronous and active-high.
  - Reset forces: all outputs 0, prev-level flop 0, counter 0, FSM in IDLE.
- Edge detect:
  - prev <= i_sig every edge.
  - rise = i_sig & ~prev; fall = ~i_sig & prev.
  - All outputs are registered and high for exactly one clk.
- Timing notation: "@N" means the output is high during the cycle after posedge N.
  - E = first posedge sampling rise; R = posedge sampling fall.
  - o_press @E; o_release @R (always, in every state).
- FSM states: IDLE, HELD, WAIT, HELD2, LONG.
- IDLE:
  - rise -> HELD, cnt <= 1.
- HELD:
  - i_sig=1 and cnt == LONG_CLKS -> o_long @E+LONG_CLKS, go LONG.
  - Otherwise, i_sig=1 -> cnt++.
  - fall -> WAIT, cnt <= 1.
  - Held through edges E..E+LONG_CLKS-1 and released at E+LONG_CLKS -> no o_long.
- WAIT:
  - rise at any edge R+1..R+DBL_WIN_CLKS inclusive -> HELD2.
  - If rise coincides with timeout, the press wins: no o_click.
  - No rise by R+DBL_WIN_CLKS -> o_click @R+DBL_WIN_CLKS, go IDLE.
- HELD2:
  - Duration ignored, no o_long.
  - fall -> o_dbl in the same cycle as o_release, go IDLE.
- LONG:
  - fall -> IDLE; no click and no dbl.
- Triple press: the third press starts a fresh sequence from IDLE.
- Counter:
  - Compares are on CNT_W-bit unsigned values.
  - Counter never wraps; in range by the parameter constraint.
- Reset mid-operation:
  - Sequence is abandoned; no pending click/dbl/long is emitted.
  - If i_sig=1 at deassertion, prev=0 makes the first edge a rise: o_press reported, new sequence starts.
- Consecutive pulses:
  - o_click and o_press are never in the same cycle. The earliest following press is at R+DBL_WIN_CLKS+1.

Test Plan:
- All scenarios use LONG_CLKS=8, DBL_WIN_CLKS=5, CNT_W=4.
- Single click: i_sig=1 edges 10-12, 0 from 13 -> o_press@10, o_release@13, o_click@18; no o_long/o_dbl.
- Long press: i_sig=1 edges 10-25 -> o_press@10, o_long@18, o_release@26; no o_click ever.
- Long boundary: i_sig=1 edges 10-17, 0 at 18 -> o_release@18, no o_long, o_click@23.
- Double click: 1 @10-11, 0 @12-14, 1 @15-16, 0 @17 -> o_press@10,15; o_release@12,17; o_dbl@17; no o_click.
- Window edge, release @12:
  - Second rise @17 -> double, o_dbl on its release.
  - Second rise @18 instead -> o_click@17, o_press@18, new sequence.
- Reset mid-hold: rise@10, rst pulse over edge 14 with i_sig=1, deassert before 15 -> outputs 0 during reset, o_press@15, o_long@23.
